// File: rtl/geo_mapper.sv
// geo_mapper: 6502 bus RAM window mapper with per-slot block/window registers; GEO_AUTOINC_EN adds window auto-increment
module geo_mapper #(
  parameter int BLOCK_W  = 8,
  parameter int WINDOW_W = 6,
  parameter int NSLOT    = 2
) (
  input  logic                          C8M,
  input  logic                          nRESET,
  input  logic                          PHI2,
  input  logic                          nIO1,
  input  logic                          nIO2,
  input  logic                          nWE,
  input  logic [7:0]                    A,
  input  logic [7:0]                    Din,
  output logic [7:0]                    Dout,
  output logic                          DOE,
  output logic [BLOCK_W+WINDOW_W+7:0]   RamAddr,
  output logic                          IncPulse
);
  localparam int SW = NSLOT > 1 ? $clog2(NSLOT) : 1;
  logic s1, s2, s3, fall, regWr, autoInc;
  logic capIo2N, capWeN;
  logic [7:0] capA, capDin, ctrlRb;
  logic [1:0] slotRb;
  logic [SW-1:0] slot;
  logic [BLOCK_W-1:0] blockReg [2**SW];
  logic [WINDOW_W-1:0] windowReg [2**SW];
`ifdef GEO_AUTOINC_EN
  logic capIo1N, incHit;
`endif
  assign fall = s3 & !s2;
  assign regWr = fall & !capIo2N & !capWeN;
  // The capture freezes once the synchronised PHI2 drops, so the commit uses the last high-phase bus values
  always_ff @(posedge C8M or negedge nRESET)
    if (!nRESET) begin
      {s1, s2, s3} <= '0;
      {capIo2N, capWeN} <= '0;
      capA <= '0;
      capDin <= '0;
`ifdef GEO_AUTOINC_EN
      capIo1N <= 1'b0;
`endif
    end else begin
      {s1, s2, s3} <= {PHI2, s1, s2};
      if (s2) begin
        {capIo2N, capWeN} <= {nIO2, nWE};
        capA <= A;
        capDin <= Din;
`ifdef GEO_AUTOINC_EN
        capIo1N <= nIO1;
`endif
      end
    end
  always_ff @(posedge C8M or negedge nRESET)
    if (!nRESET) begin
      slot <= '0;
      for (int i = 0; i < 2**SW; i++) begin
        blockReg[i] <= '0;
        windowReg[i] <= '0;
      end
    end else if (regWr) begin
      if (capA == 8'hFF) blockReg[slot] <= capDin[BLOCK_W-1:0];
      if (capA == 8'hFE) windowReg[slot] <= capDin[WINDOW_W-1:0];
      if (capA == 8'hFD) slot <= NSLOT > 1 ? SW'(capDin[2:1]) : '0;
    end
`ifdef GEO_AUTOINC_EN
    else if (incHit)
      {blockReg[slot], windowReg[slot]} <= {blockReg[slot], windowReg[slot]} + (BLOCK_W+WINDOW_W)'(1);
`endif
`ifdef GEO_AUTOINC_EN
  // IO2 wins when both pages are selected, so the increment requires nIO2 high
  assign incHit = fall & !capIo1N & capIo2N & (capA == 8'hFF) & autoInc;
  always_ff @(posedge C8M or negedge nRESET)
    if (!nRESET) begin
      autoInc <= 1'b0;
      IncPulse <= 1'b0;
    end else begin
      IncPulse <= incHit;
      if (regWr && capA == 8'hFD) autoInc <= capDin[0];
    end
`else
  assign autoInc = 1'b0;
  assign IncPulse = 1'b0;
`endif
  assign slotRb = NSLOT > 1 ? 2'(slot) : 2'b00;
  assign ctrlRb = {5'b0, slotRb, autoInc};
  assign Dout = A == 8'hFF ? 8'(blockReg[slot]) :
                A == 8'hFE ? 8'(windowReg[slot]) :
                A == 8'hFD ? ctrlRb : 8'h00;
  assign DOE = PHI2 & nWE & (!nIO1 | (!nIO2 & (A >= 8'hFD)));
  assign RamAddr = {blockReg[slot], windowReg[slot], A};
endmodule

// File: tb/tb_geo_mapper.sv
// tb_geo_mapper: directed and random bus cycles checked against an arithmetic model of the mapper
module tb_geo_mapper;
  localparam int BW = 8, WW = 6, NS = 2;
`ifdef GEO_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic C8M = 1'b0, nRESET = 1'b0, PHI2 = 1'b0, nIO1 = 1'b1, nIO2 = 1'b1, nWE = 1'b1;
  logic [7:0] A = 8'h00, Din = 8'h00;
  logic [7:0] Dout;
  logic DOE, IncPulse;
  logic [BW+WW+7:0] RamAddr;
  int nAssert = 0, nFail = 0;
  int mBlk[4], mWin[4], mSlot, mAi, incSeen, expInc;

  always #5 C8M = ~C8M;

  geo_mapper #(.BLOCK_W(BW), .WINDOW_W(WW), .NSLOT(NS)) dut (
    .C8M(C8M), .nRESET(nRESET), .PHI2(PHI2), .nIO1(nIO1), .nIO2(nIO2), .nWE(nWE),
    .A(A), .Din(Din), .Dout(Dout), .DOE(DOE), .RamAddr(RamAddr), .IncPulse(IncPulse)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    for (int i = 0; i < 4; i++) begin
      mBlk[i] = 0;
      mWin[i] = 0;
    end
    mSlot = 0;
    mAi = 0;
  endtask

  task automatic mCommit(input logic io1, input logic io2, input logic we, input int a, input int d);
    expInc = 0;
    if (!io2) begin
      if (!we && a == 255) mBlk[mSlot] = d % (1 << BW);
      if (!we && a == 254) mWin[mSlot] = d % (1 << WW);
      if (!we && a == 253) begin
        mSlot = (d / 2) % NS;
        mAi = AUTO ? d % 2 : 0;
      end
    end else if (!io1 && a == 255 && mAi == 1) begin
      mWin[mSlot] = mWin[mSlot] + 1;
      if (mWin[mSlot] == (1 << WW)) begin
        mWin[mSlot] = 0;
        mBlk[mSlot] = (mBlk[mSlot] + 1) % (1 << BW);
      end
      expInc = 1;
    end
  endtask

  task automatic busCycle(input logic io1, input logic io2, input logic we, input logic [7:0] a, input logic [7:0] d);
    @(negedge C8M);
    nIO1 = io1; nIO2 = io2; nWE = we; A = a; Din = d; PHI2 = 1'b1;
    repeat (4) @(negedge C8M);
    PHI2 = 1'b0;
    incSeen = 0;
    repeat (5) begin
      @(negedge C8M);
      incSeen += int'(IncPulse);
    end
    nIO1 = 1'b1; nIO2 = 1'b1; nWE = 1'b1;
    mCommit(io1, io2, we, int'(a), int'(d));
    chk("incpulse_count", incSeen, expInc);
  endtask

  task automatic peekReg(input logic [7:0] a);
    int exp;
    @(negedge C8M);
    nIO2 = 1'b0; nWE = 1'b1; A = a; PHI2 = 1'b1;
    #1;
    exp = a == 8'hFF ? mBlk[mSlot] : a == 8'hFE ? mWin[mSlot] : a == 8'hFD ? mSlot * 2 + mAi : 0;
    chk("dout", 32'(Dout), exp);
    chk("doe_io2", 32'(DOE), a >= 8'hFD ? 1 : 0);
    #1;
    PHI2 = 1'b0; nIO2 = 1'b1;
  endtask

  task automatic peekRam(input logic [7:0] a);
    @(negedge C8M);
    A = a; nIO1 = 1'b0; nWE = 1'b1; PHI2 = 1'b1;
    #1;
    chk("ramaddr", 32'(RamAddr), mBlk[mSlot] * (1 << (WW + 8)) + mWin[mSlot] * 256 + int'(a));
    chk("doe_io1", 32'(DOE), 1);
    #1;
    PHI2 = 1'b0; nIO1 = 1'b1;
  endtask

  task automatic doReset();
    @(negedge C8M);
    nRESET = 1'b0;
    mReset();
    repeat (2) @(negedge C8M);
    nRESET = 1'b1;
  endtask

  initial begin
    mReset();
    A = 8'h10;
    repeat (3) @(negedge C8M);
    #1;
    chk("reset_ramaddr", 32'(RamAddr), 32'h10);
    chk("reset_incpulse", 32'(IncPulse), 0);
    nRESET = 1'b1;
    peekReg(8'hFF);
    peekReg(8'hFE);
    peekReg(8'hFD);
    busCycle(1, 0, 0, 8'hFF, 8'h5A);
    busCycle(1, 0, 0, 8'hFE, 8'h3F);
    peekRam(8'h10);
    chk("map_5a_3f_10", 32'(RamAddr), 32'h16BF10);
    doReset();
    busCycle(1, 0, 0, 8'hFD, 8'h02);
    busCycle(1, 0, 0, 8'hFF, 8'h11);
    busCycle(1, 0, 0, 8'hFD, 8'h00);
    peekReg(8'hFF);
    busCycle(1, 0, 0, 8'hFD, 8'h02);
    peekReg(8'hFF);
    peekReg(8'hFD);
    busCycle(1, 0, 0, 8'hFD, 8'h01);
    peekReg(8'hFD);
    busCycle(1, 0, 0, 8'hFF, 8'h07);
    busCycle(1, 0, 0, 8'hFE, 8'h3F);
    busCycle(0, 1, 1, 8'hFF, 8'h00);
    peekReg(8'hFF);
    peekReg(8'hFE);
    busCycle(1, 0, 0, 8'hFF, 8'hFF);
    busCycle(1, 0, 0, 8'hFE, 8'h3F);
    busCycle(0, 1, 0, 8'hFF, 8'h99);
    peekReg(8'hFF);
    peekReg(8'hFE);
    peekRam(8'hFF);
    busCycle(0, 0, 0, 8'hFF, 8'h22);
    peekReg(8'hFF);
    peekReg(8'hFE);
    busCycle(1, 0, 0, 8'hFE, 8'h11);
    @(negedge C8M);
    nIO2 = 1'b0; nWE = 1'b0; A = 8'hFE; Din = 8'h2A; PHI2 = 1'b1;
    repeat (3) @(negedge C8M);
    nRESET = 1'b0;
    mReset();
    #1;
    chk("async_reset_ramaddr", 32'(RamAddr), 32'hFE);
    @(negedge C8M);
    PHI2 = 1'b0;
    repeat (2) @(negedge C8M);
    nRESET = 1'b1;
    repeat (6) @(negedge C8M);
    nIO2 = 1'b1; nWE = 1'b1;
    peekReg(8'hFE);
    busCycle(1, 0, 0, 8'hFE, 8'h15);
    peekReg(8'hFE);
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [7:0] d, ra;
      op = $urandom_range(0, 5);
      d = 8'($urandom);
      ra = 8'($urandom);
      case (op)
        0: busCycle(1, 0, 0, 8'hFF, d);
        1: busCycle(1, 0, 0, 8'hFE, d);
        2: busCycle(1, 0, 0, 8'hFD, d);
        3: busCycle(0, 1, 1'($urandom), 8'hFF, d);
        4: busCycle(0, 1, 1'($urandom), ra, d);
        default: busCycle(0, 0, 0, 8'hFF, d);
      endcase
      peekRam(ra);
      peekReg(8'hFD + 8'($urandom_range(0, 2)));
      peekReg(ra);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
